// File: rtl/wordle_pkg.sv
// Shared definitions for the Wordle guess engine.
//   state_e : one-hot controller states
//   ABSENT / PRESENT / CORRECT : per-position result codes
//   ASCII_* : letter range bounds and the case bit
package wordle_pkg;

   typedef enum logic [4:0] {
      S_I      = 5'b00001,
      S_ENTRY  = 5'b00010,
      S_GREEN  = 5'b00100,
      S_YELLOW = 5'b01000,
      S_DONE   = 5'b10000
   } state_e;

   localparam logic [1:0] ABSENT  = 2'b00;
   localparam logic [1:0] PRESENT = 2'b01;
   localparam logic [1:0] CORRECT = 2'b10;

   localparam logic [7:0] ASCII_UP_A = 8'h41;
   localparam logic [7:0] ASCII_UP_Z = 8'h5A;
   localparam logic [7:0] ASCII_LO_A = 8'h61;
   localparam logic [7:0] ASCII_LO_Z = 8'h7A;
   localparam logic [7:0] CASE_BIT   = 8'h20;

endpackage

// File: rtl/wordle_letter_filter.sv
// Combinational letter check: accepts A..Z and a..z, folds lower case to upper.
//   letter  : raw ASCII code
//   upper_c : upper-case letter (meaningful only when ok_c)
//   ok_c    : 1 when the code is an alphabetic letter
module wordle_letter_filter
   import wordle_pkg::*;
(
   input  logic [7:0] letter,
   output logic [7:0] upper_c,
   output logic       ok_c
);

   always_comb begin
      upper_c = letter;
      ok_c    = 1'b0;
      if (letter >= ASCII_UP_A && letter <= ASCII_UP_Z) begin
         ok_c = 1'b1;
      end else if (letter >= ASCII_LO_A && letter <= ASCII_LO_Z) begin
         ok_c    = 1'b1;
         upper_c = letter & ~CASE_BIT;
      end
   end

endmodule

// File: rtl/wordle_guess_engine.sv
// Wordle guess engine: buffers typed letters, then scores a submitted guess
// against the latched secret with a green pass and a yellow pass, one position
// per cycle each.
//   Clk, reset                 : clock, async active-high reset
//   Start, Ack, secret         : game start / end acknowledge / target word
//   letter_valid, letter, del, submit : entry controls
//   letter_ready, bad_letter, letter_count : entry status
//   result, result_valid       : per-position codes and their strobe
//   guess_num, win, lose       : game progress
//   q_I .. q_Done              : one-hot state
module wordle_guess_engine
   import wordle_pkg::*;
#(
   parameter int unsigned WORD_LEN    = 5,
   parameter int unsigned MAX_GUESSES = 6
) (
   input  logic                    Clk,
   input  logic                    reset,
   input  logic                    Start,
   input  logic                    Ack,
   input  logic [8*WORD_LEN-1:0]   secret,
   input  logic                    letter_valid,
   input  logic [7:0]              letter,
   input  logic                    del,
   input  logic                    submit,
   output logic                    letter_ready,
   output logic                    bad_letter,
   output logic [3:0]              letter_count,
   output logic [2*WORD_LEN-1:0]   result,
   output logic                    result_valid,
   output logic [3:0]              guess_num,
   output logic                    win,
   output logic                    lose,
   output logic                    q_I,
   output logic                    q_Entry,
   output logic                    q_Green,
   output logic                    q_Yellow,
   output logic                    q_Done
);

   localparam int unsigned   IDX_W    = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_LEN - 1);
   localparam logic [3:0]    LEN_4    = 4'(WORD_LEN);
   localparam logic [3:0]    MAX_4    = 4'(MAX_GUESSES);

   state_e                state_q, state_d;
   logic [IDX_W-1:0]      idx_q;
   logic [WORD_LEN-1:0]   used_q;
   logic [7:0]            sec_q   [WORD_LEN];
   logic [7:0]            guess_q [WORD_LEN];
   logic [1:0]            code_q  [WORD_LEN];
   logic [3:0]            count_q, count_d;

   logic [7:0]            upper_c;
   logic                  letter_ok_c;
   logic                  do_letter, do_bad, do_submit;
   logic                  last_step, green_hit, all_correct, lose_d;
   logic                  yellow_hit;
   logic [IDX_W-1:0]      yellow_j;
   logic [2*WORD_LEN-1:0] result_d;

   wordle_letter_filter u_filter (
      .letter  (letter),
      .upper_c (upper_c),
      .ok_c    (letter_ok_c)
   );

   assign letter_count = count_q;
   assign q_I      = (state_q == S_I);
   assign q_Entry  = (state_q == S_ENTRY);
   assign q_Green  = (state_q == S_GREEN);
   assign q_Yellow = (state_q == S_YELLOW);
   assign q_Done   = (state_q == S_DONE);

   // Yellow search: lowest-index unused secret letter equal to the current guess letter.
   always_comb begin
      yellow_hit = 1'b0;
      yellow_j   = '0;
      for (int j = int'(WORD_LEN) - 1; j >= 0; j--) begin
         if (!used_q[j] && sec_q[j] == guess_q[idx_q]) begin
            yellow_hit = 1'b1;
            yellow_j   = IDX_W'(j);
         end
      end
      if (code_q[idx_q] == CORRECT) yellow_hit = 1'b0;
   end

   // Final result word, including the yellow update of the position being scanned.
   always_comb begin
      all_correct = 1'b1;
      result_d    = '0;
      for (int i = 0; i < int'(WORD_LEN); i++) begin
         if (code_q[i] != CORRECT) all_correct = 1'b0;
         result_d[2*(int'(WORD_LEN)-1-i) +: 2] =
            (yellow_hit && IDX_W'(i) == idx_q) ? PRESENT : code_q[i];
      end
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) state_q <= S_I;
      else       state_q <= state_d;
   end

   // Next-state and entry decode.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      do_letter = 1'b0;
      do_bad    = 1'b0;
      do_submit = 1'b0;
      last_step = (idx_q == LAST_IDX);
      green_hit = (sec_q[idx_q] == guess_q[idx_q]);
      lose_d    = ((guess_num + 4'd1) == MAX_4);
      case (state_q)
         S_I: begin
            if (Start) begin
               state_d = S_ENTRY;
               count_d = '0;
            end
         end
         S_ENTRY: begin
            if (submit && count_q == LEN_4) begin
               do_submit = 1'b1;
               state_d   = S_GREEN;
            end else if (del) begin
               if (count_q != '0) count_d = count_q - 4'd1;
            end else if (letter_valid && count_q < LEN_4) begin
               if (letter_ok_c) begin
                  do_letter = 1'b1;
                  count_d   = count_q + 4'd1;
               end else begin
                  do_bad = 1'b1;
               end
            end
         end
         S_GREEN: begin
            if (last_step) state_d = S_YELLOW;
         end
         S_YELLOW: begin
            if (last_step) begin
               count_d = '0;
               state_d = (all_correct || lose_d) ? S_DONE : S_ENTRY;
            end
         end
         S_DONE: begin
            if (Ack) state_d = S_I;
         end
         default: state_d = S_I;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         idx_q        <= '0;
         used_q       <= '0;
         count_q      <= '0;
         guess_num    <= '0;
         win          <= 1'b0;
         lose         <= 1'b0;
         result       <= '0;
         result_valid <= 1'b0;
         bad_letter   <= 1'b0;
         letter_ready <= 1'b0;
         for (int i = 0; i < int'(WORD_LEN); i++) begin
            sec_q[i]   <= '0;
            guess_q[i] <= '0;
            code_q[i]  <= ABSENT;
         end
      end else begin
         result_valid <= 1'b0;
         bad_letter   <= do_bad;
         count_q      <= count_d;
         letter_ready <= (state_d == S_ENTRY) && (count_d < LEN_4);
         case (state_q)
            S_I: begin
               if (Start) begin
                  guess_num <= '0;
                  win       <= 1'b0;
                  lose      <= 1'b0;
                  result    <= '0;
                  for (int i = 0; i < int'(WORD_LEN); i++)
                     sec_q[i] <= secret[8*(int'(WORD_LEN)-1-i) +: 8];
               end
            end
            S_ENTRY: begin
               if (do_letter) guess_q[IDX_W'(count_q)] <= upper_c;
               if (do_submit) begin
                  idx_q  <= '0;
                  used_q <= '0;
                  for (int i = 0; i < int'(WORD_LEN); i++) code_q[i] <= ABSENT;
               end
            end
            S_GREEN: begin
               if (green_hit) begin
                  code_q[idx_q] <= CORRECT;
                  used_q[idx_q] <= 1'b1;
               end
               idx_q <= last_step ? '0 : idx_q + IDX_W'(1);
            end
            S_YELLOW: begin
               if (yellow_hit) begin
                  code_q[idx_q]    <= PRESENT;
                  used_q[yellow_j] <= 1'b1;
               end
               idx_q <= last_step ? '0 : idx_q + IDX_W'(1);
               if (last_step) begin
                  result       <= result_d;
                  result_valid <= 1'b1;
                  guess_num    <= guess_num + 4'd1;
                  win          <= all_correct;
                  lose         <= !all_correct && lose_d;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_wordle_guess_engine.sv
// Self-checking bench for wordle_guess_engine (WORD_LEN=5, MAX_GUESSES=6).
module tb_wordle_guess_engine;

   localparam int WL   = 5;
   localparam int MAXG = 6;

   logic            Clk = 1'b0;
   logic            reset;
   logic            Start, Ack, letter_valid, del, submit;
   logic [8*WL-1:0] secret;
   logic [7:0]      letter;
   logic            letter_ready, bad_letter, result_valid, win, lose;
   logic [3:0]      letter_count, guess_num;
   logic [2*WL-1:0] result;
   logic            q_I, q_Entry, q_Green, q_Yellow, q_Done;

   wordle_guess_engine #(.WORD_LEN(WL), .MAX_GUESSES(MAXG)) dut (
      .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack), .secret(secret),
      .letter_valid(letter_valid), .letter(letter), .del(del), .submit(submit),
      .letter_ready(letter_ready), .bad_letter(bad_letter), .letter_count(letter_count),
      .result(result), .result_valid(result_valid), .guess_num(guess_num),
      .win(win), .lose(lose), .q_I(q_I), .q_Entry(q_Entry), .q_Green(q_Green),
      .q_Yellow(q_Yellow), .q_Done(q_Done)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [2*WL-1:0] res;
      logic            win;
      logic            lose;
      logic [3:0]      gnum;
   } exp_t;

   exp_t  sb[$];
   int    checks = 0;
   int    errors = 0;
   string cur_secret;
   int    exp_gnum;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   function automatic logic [8*WL-1:0] pack(input string s);
      logic [8*WL-1:0] r;
      for (int i = 0; i < WL; i++) r[8*(WL-1-i) +: 8] = s[i];
      return r;
   endfunction

   // Reference scoring: greens first, then yellows from remaining letter counts.
   function automatic logic [2*WL-1:0] model(input string s, input string g);
      int              cnt[26];
      logic [1:0]      c[WL];
      logic [2*WL-1:0] r;
      for (int k = 0; k < 26; k++) cnt[k] = 0;
      for (int i = 0; i < WL; i++) begin
         if (g[i] == s[i]) c[i] = 2'b10;
         else begin
            c[i] = 2'b00;
            cnt[int'(s[i]) - 65]++;
         end
      end
      for (int i = 0; i < WL; i++) begin
         if (c[i] != 2'b10 && cnt[int'(g[i]) - 65] > 0) begin
            c[i] = 2'b01;
            cnt[int'(g[i]) - 65]--;
         end
      end
      r = '0;
      for (int i = 0; i < WL; i++) r[2*(WL-1-i) +: 2] = c[i];
      return r;
   endfunction

   task automatic type_char(input byte c);
      letter_valid = 1'b1;
      letter       = c;
      step();
      letter_valid = 1'b0;
      letter       = 8'h00;
   endtask

   task automatic type_str(input string s);
      for (int i = 0; i < s.len(); i++) type_char(s[i]);
   endtask

   task automatic start_game(input string s);
      secret = pack(s);
      Start  = 1'b1;
      step();
      Start  = 1'b0;
      cur_secret = s;
      exp_gnum   = 0;
      check("start_entry", q_Entry, 1);
      check("start_gnum", guess_num, 0);
      check("start_ready", letter_ready, 1);
   endtask

   task automatic submit_and_check(input string g);
      exp_t e;
      exp_t got;
      int   cyc;
      exp_gnum++;
      e.res  = model(cur_secret, g);
      e.win  = (e.res == {WL{2'b10}});
      e.lose = !e.win && (exp_gnum == MAXG);
      e.gnum = 4'(exp_gnum);
      sb.push_back(e);
      submit = 1'b1;
      step();
      submit = 1'b0;
      cyc = 1;
      while (!result_valid && cyc < 40) begin
         step();
         cyc++;
      end
      check("latency", cyc, 2*WL+1);
      if (sb.size() > 0) begin
         got = sb.pop_front();
         check({"result_", g}, result, got.res);
         check({"gnum_", g}, guess_num, got.gnum);
         check({"win_", g}, win, got.win);
         check({"lose_", g}, lose, got.lose);
         check({"done_", g}, q_Done, got.win | got.lose);
      end
      step();
      check("rv_pulse", result_valid, 0);
      check("result_hold", result, got.res);
   endtask

   task automatic play(input string g);
      type_str(g);
      submit_and_check(g);
   endtask

   initial begin
      int rv_seen;
      reset = 1'b1; Start = 0; Ack = 0; letter_valid = 0; del = 0; submit = 0;
      secret = '0; letter = '0;
      step(); step();
      check("rst_qi", q_I, 1);
      check("rst_count", letter_count, 0);
      check("rst_result", result, 0);
      check("rst_gnum", guess_num, 0);
      check("rst_ready", letter_ready, 0);
      reset = 1'b0;
      step();
      check("idle_qi", q_I, 1);

      // Exact hit
      start_game("CRIMP");
      play("CRIMP");
      check("crimp_const", result, 10'b1010101010);
      Start = 1'b1; step(); Start = 1'b0;
      check("start_in_done", q_Done, 1);
      Ack = 1'b1; step(); Ack = 1'b0;
      check("ack_qi", q_I, 1);

      // Repeated letters without extra yellows
      start_game("ROBOT");
      play("OOOOO");
      check("robot_const", result, 10'b0010001000);
      check("robot_entry", q_Entry, 1);
      play("ROBOT");
      Ack = 1'b1; step(); Ack = 1'b0;

      // Entry editing, then a full losing game
      start_game("ABBOT");
      del = 1'b1; step(); del = 1'b0;
      check("del_at_zero", letter_count, 0);
      type_str("ab");
      check("bad_before", bad_letter, 0);
      type_char("3");
      check("bad_pulse", bad_letter, 1);
      check("count_ab3", letter_count, 2);
      del = 1'b1; step(); del = 1'b0;
      check("bad_one_cycle", bad_letter, 0);
      check("count_del", letter_count, 1);
      type_str("cde");
      check("count_cde", letter_count, 4);
      submit = 1'b1; step(); submit = 1'b0;
      check("submit_short_state", q_Entry, 1);
      check("submit_short_count", letter_count, 4);
      del = 1'b1; letter_valid = 1'b1; letter = "Q"; step();
      del = 1'b0; letter_valid = 1'b0;
      check("del_priority", letter_count, 3);
      type_str("ey");
      check("full_ready", letter_ready, 0);
      type_char("Z");
      check("full_ignore", letter_count, 5);
      check("full_no_bad", bad_letter, 0);
      submit_and_check("ACDEY");
      play("BOBBY");
      check("bobby_const", result, 10'b0101100000);
      play("TOBBA");
      play("XXXXX");
      play("ZZZZZ");
      play("QQQQQ");
      check("lose_flag", lose, 1);
      check("lose_gnum", guess_num, 6);
      step();
      check("lose_hold", lose, 1);
      Ack = 1'b1; step(); Ack = 1'b0;
      check("lose_ack_qi", q_I, 1);

      // Reset during the green scan
      start_game("CRIMP");
      type_str("CRIMP");
      submit = 1'b1; step(); submit = 1'b0;
      step(); step();
      check("mid_green", q_Green, 1);
      reset = 1'b1;
      #1;
      check("arst_qi", q_I, 1);
      check("arst_rv", result_valid, 0);
      check("arst_count", letter_count, 0);
      check("arst_result", result, 0);
      check("arst_win", win, 0);
      check("arst_gnum", guess_num, 0);
      step();
      reset = 1'b0;
      rv_seen = 0;
      for (int k = 0; k < 15; k++) begin
         step();
         if (result_valid) rv_seen++;
      end
      check("arst_no_rv", rv_seen, 0);
      check("arst_still_i", q_I, 1);
      start_game("PLUMB");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
